ext_bus_ctrl: RTL and testbench

- Owns the CPU clock-enable divider and the external-bus cycle generator; sits directly downstream of the CPU's registered address/data/write-enable outputs.
- Drives the off-chip 65xx-style bus: address, data, RWB, chip select and PHI2.
- Stretches the CPU clock enable for slow external devices, using programmable wait states plus an external RDY input.
- Returns latched read data for the top-level CPU data-in mux.

---
 rtl/ext_bus_pkg.sv | 20 ++
 rtl/ext_bus_ctrl_rdy_sync.sv | 31 +++
 rtl/ext_bus_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ext_bus_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// +-----------------------------------------------------------------------+
// | ext_bus_pkg: shared types and constants for the external bus ctrl     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package ext_bus_pkg;

  localparam int         CLKEN_BITS_DEF   = 2;
  localparam logic [7:0] EXT_BUS_ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/ext_bus_ctrl_rdy_sync.sv
// +-----------------------------------------------------------------------+
// | rdy_sync: two-flop synchroniser, resets to 1 (bus ready)              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rdy_sync (
  input  logic clk,
  input  logic resb,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/ext_bus_ctrl.sv
// +-----------------------------------------------------------------------+
// | ext_bus_ctrl: CPU clock-enable divider and 65xx external bus cycles   |
// | Optional HOLD timeout via EXT_BUS_TIMEOUT_EN.            Rev 1.0      |
// +-----------------------------------------------------------------------+
`default_nettype none

module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int CLKEN_BITS = CLKEN_BITS_DEF,
  parameter int WS_BITS    = 3,
  parameter int TO_BITS    = 8
) (
  input  logic               clk,
  input  logic               resb,
  input  logic               bus_e,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_dout,
  input  logic               cpu_we,
  input  logic [WS_BITS-1:0] ws_cfg,
  input  logic               ext_rdy,
  input  logic [7:0]         ext_din,
  output logic               cpu_clken,
  output logic               via_clken,
  output logic               phi2,
  output logic [15:0]        ext_addr,
  output logic [7:0]         ext_dout,
  output logic               ext_doe,
  output logic               ext_rwb,
  output logic               ext_csb,
  output logic [7:0]         ext_rdata,
  output logic               bus_err
);

  logic [CLKEN_BITS-1:0] div_q, div_d;
  bus_state_e            state_q, state_d;
  logic [WS_BITS-1:0]    wcnt_q, wcnt_d;
  logic                  clken_q, clken_d;
  logic                  via_q;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            dout_q, dout_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  doe_q, doe_d;
  logic                  rwb_q, rwb_d;
  logic                  csb_q, csb_d;
  logic                  tick;
  logic                  done;
  logic                  rdy_s;

`ifdef EXT_BUS_TIMEOUT_EN
  logic [TO_BITS-1:0]    tcnt_q, tcnt_d;
  logic                  berr_q, berr_d;
  logic                  timeout_hit;
`endif

  rdy_sync u_rdy_sync (
    .clk  (clk),
    .resb (resb),
    .d    (ext_rdy),
    .q    (rdy_s)
  );

  assign tick = &div_q;

  always_comb begin
    div_d   = div_q + 1'b1;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    clken_d = 1'b0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    doe_d   = doe_q;
    rwb_d   = rwb_q;
    csb_d   = csb_q;
    done    = 1'b0;
`ifdef EXT_BUS_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    berr_d      = berr_q;
    timeout_hit = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (bus_e) begin
            state_d = ACCESS;
            wcnt_d  = ws_cfg;
            addr_d  = cpu_addr;
            dout_d  = cpu_dout;
            rwb_d   = !cpu_we;
            csb_d   = 1'b0;
            doe_d   = cpu_we;
          end else begin
            clken_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (tick) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 1'b1;
          end else if (rdy_s) begin
            done = 1'b1;
          end else begin
            state_d = HOLD;
`ifdef EXT_BUS_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (rdy_s) begin
            done = 1'b1;
          end
`ifdef EXT_BUS_TIMEOUT_EN
          else begin
            tcnt_d = tcnt_q + 1'b1;
            if (&tcnt_d) begin
              done        = 1'b1;
              timeout_hit = 1'b1;
              berr_d      = 1'b1;
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // The released tick doubles as the CPU enable for the completed cycle
    if (done) begin
      clken_d = 1'b1;
      state_d = IDLE;
      csb_d   = 1'b1;
      doe_d   = 1'b0;
      rwb_d   = 1'b1;
      if (rwb_q) begin
`ifdef EXT_BUS_TIMEOUT_EN
        rdata_d = timeout_hit ? EXT_BUS_ERR_DATA : ext_din;
`else
        rdata_d = ext_din;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      div_q   <= '0;
      state_q <= IDLE;
      wcnt_q  <= '0;
      clken_q <= 1'b0;
      via_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      rwb_q   <= 1'b1;
      csb_q   <= 1'b1;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      clken_q <= clken_d;
      via_q   <= clken_q;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      rwb_q   <= rwb_d;
      csb_q   <= csb_d;
    end
  end

`ifdef EXT_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      tcnt_q <= '0;
      berr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      berr_q <= berr_d;
    end
  end

  assign bus_err = berr_q;
`else
  assign bus_err = 1'b0;
`endif

  assign cpu_clken = clken_q;
  assign via_clken = via_q;
  assign phi2      = div_q[CLKEN_BITS-1];
  assign ext_addr  = addr_q;
  assign ext_dout  = dout_q;
  assign ext_doe   = doe_q;
  assign ext_rwb   = rwb_q;
  assign ext_csb   = csb_q;
  assign ext_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_bus_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_ext_bus_ctrl: directed scoreboard bench for ext_bus_ctrl           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_ext_bus_ctrl;

  logic        clk = 1'b0;
  logic        resb;
  logic        bus_e;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [2:0]  ws_cfg;
  logic        ext_rdy;
  logic [7:0]  ext_din;
  logic        cpu_clken, via_clken, phi2;
  logic [15:0] ext_addr;
  logic [7:0]  ext_dout, ext_rdata;
  logic        ext_doe, ext_rwb, ext_csb, bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          n, lo, bad;

  always #5 clk = ~clk;

  ext_bus_ctrl dut (
    .clk       (clk),
    .resb      (resb),
    .bus_e     (bus_e),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .ws_cfg    (ws_cfg),
    .ext_rdy   (ext_rdy),
    .ext_din   (ext_din),
    .cpu_clken (cpu_clken),
    .via_clken (via_clken),
    .phi2      (phi2),
    .ext_addr  (ext_addr),
    .ext_dout  (ext_dout),
    .ext_doe   (ext_doe),
    .ext_rwb   (ext_rwb),
    .ext_csb   (ext_csb),
    .ext_rdata (ext_rdata),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step negedges until a cpu_clken pulse; act_kind 1 scrambles ws_cfg/cpu_we,
  // act_kind 2 raises ext_rdy, both at step act_at.
  task automatic wait_clken(input int max_clk, input int act_at, input int act_kind,
                            input logic exp_doe, output int cnt, output int csb_lo,
                            output int bad_drv);
    cnt = 0; csb_lo = 0; bad_drv = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == act_at && act_kind == 1) begin
        ws_cfg = 3'd0;
        cpu_we = 1'b0;
      end
      if (cnt == act_at && act_kind == 2) ext_rdy = 1'b1;
      if (ext_csb === 1'b0) begin
        csb_lo++;
        if (ext_doe !== exp_doe || ext_rwb !== !exp_doe) bad_drv++;
      end else if (ext_doe !== 1'b0 || ext_rwb !== 1'b1) begin
        bad_drv++;
      end
    end while (cpu_clken !== 1'b1 && cnt < max_clk);
    chk("clken_seen", {31'd0, cpu_clken}, 32'd1);
  endtask

  task automatic chk_rdata(input string tag);
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk(tag, {24'd0, ext_rdata}, {24'd0, e});
  endtask

  initial begin
    resb = 1'b0; bus_e = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
    ws_cfg = '0; ext_rdy = 1'b1; ext_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_clken", {31'd0, cpu_clken}, 32'd0);
    chk("rst_via", {31'd0, via_clken}, 32'd0);
    chk("rst_phi2", {31'd0, phi2}, 32'd0);
    chk("rst_csb", {31'd0, ext_csb}, 32'd1);
    chk("rst_rwb", {31'd0, ext_rwb}, 32'd1);
    chk("rst_doe", {31'd0, ext_doe}, 32'd0);
    chk("rst_addr", {16'd0, ext_addr}, 32'd0);
    chk("rst_dout", {24'd0, ext_dout}, 32'd0);
    chk("rst_rdata", {24'd0, ext_rdata}, 32'd0);
    chk("rst_berr", {31'd0, bus_err}, 32'd0);
    resb = 1'b1;

    // Internal accesses: steady one-in-four cadence, bus idle
    wait_clken(16, 0, 0, 1'b0, n, lo, bad);
    chk("first_clken", n, 4);
    @(negedge clk);
    chk("via_delay", {30'd0, cpu_clken, via_clken}, 32'b01);
    @(negedge clk);
    chk("phi2_high", {31'd0, phi2}, 32'd1);
    wait_clken(16, 0, 0, 1'b0, n, lo, bad);
    chk("int_gap0", n, 2);
    for (int i = 0; i < 19; i++) begin
      wait_clken(16, 0, 0, 1'b0, n, lo, bad);
      chk("int_gap", n, 4);
      chk("int_bus_idle", lo + bad, 0);
    end

    // External read, no wait states
    cpu_addr = 16'h9000; bus_e = 1'b1; cpu_we = 1'b0; ws_cfg = 3'd0; ext_din = 8'h5A;
    exp_q.push_back(8'h5A);
    wait_clken(60, 0, 0, 1'b0, n, lo, bad);
    bus_e = 1'b0;
    chk("rd_gap", n, 8);
    chk("rd_csb_lo", lo, 4);
    chk("rd_drive", bad, 0);
    chk_rdata("rd_data");
    chk("rd_addr", {16'd0, ext_addr}, 32'h9000);

    // External write, 3 wait states; ws_cfg/cpu_we scrambled mid-access
    cpu_addr = 16'hA000; cpu_dout = 8'hA5; cpu_we = 1'b1; ws_cfg = 3'd3;
    ext_din = 8'hC3; bus_e = 1'b1;
    exp_q.push_back(8'h5A);
    wait_clken(80, 6, 1, 1'b1, n, lo, bad);
    chk("wr_gap", n, 20);
    chk("wr_csb_lo", lo, 16);
    chk("wr_drive", bad, 0);
    chk_rdata("wr_rdata_kept");
    chk("wr_dout", {24'd0, ext_dout}, 32'hA5);
    chk("wr_addr", {16'd0, ext_addr}, 32'hA000);

    // Back-to-back read held off by ext_rdy; rises 1.5 clk before a tick
    cpu_addr = 16'h9002; cpu_we = 1'b0; ws_cfg = 3'd0; ext_din = 8'h77; ext_rdy = 1'b0;
    exp_q.push_back(8'h77);
    wait_clken(120, 42, 2, 1'b0, n, lo, bad);
    chk("hold_gap", n, 48);
    chk("hold_csb_lo", lo, 44);
    chk("hold_drive", bad, 0);
    chk_rdata("hold_data");

    // Reset pulse in the middle of a long access
    cpu_addr = 16'hB000; ws_cfg = 3'd7; ext_din = 8'h3C;
    repeat (10) @(negedge clk);
    chk("pre_rst_csb", {31'd0, ext_csb}, 32'd0);
    resb = 1'b0;
    #1;
    chk("arst_csb", {31'd0, ext_csb}, 32'd1);
    chk("arst_doe", {31'd0, ext_doe}, 32'd0);
    chk("arst_rwb", {31'd0, ext_rwb}, 32'd1);
    chk("arst_clken", {31'd0, cpu_clken}, 32'd0);
    chk("arst_addr", {16'd0, ext_addr}, 32'd0);
    chk("arst_rdata", {24'd0, ext_rdata}, 32'd0);
    @(negedge clk);
    resb = 1'b1;
    exp_q.push_back(8'h3C);
    wait_clken(80, 0, 0, 1'b0, n, lo, bad);
    bus_e = 1'b0;
    chk("fresh_gap", n, 36);
    chk("fresh_csb_lo", lo, 32);
    chk_rdata("fresh_data");
    chk("fresh_addr", {16'd0, ext_addr}, 32'hB000);
    wait_clken(16, 0, 0, 1'b0, n, lo, bad);
    chk("post_gap", n, 4);
    chk("sb_drained", exp_q.size(), 0);
`ifndef EXT_BUS_TIMEOUT_EN
    chk("berr_tied", {31'd0, bus_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
